// File: rtl/sum_sq_feed.sv
// Computes a*a + b*b with one shared shift-add multiplier, then hands the
// result to the sqrt stage over its start/busy handshake.
module sum_sq_feed #(
  parameter  int W     = 8,
  localparam int OUT_W = 2*W+1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [W-1:0]     a_bi,
  input  logic [W-1:0]     b_bi,
  input  logic             start_i,
  output logic             busy_o,
  output logic [OUT_W-1:0] y_bo,
  output logic             sq_start_o,
  input  logic             sq_busy_i
);

  localparam int CNT_W = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, MUL_A, MUL_B, SEND} state_t;

  state_t           state;
  logic [W-1:0]     opa;
  logic [W-1:0]     opb;
  logic [W-1:0]     mult_op;
  logic [CNT_W-1:0] cnt;
  logic [OUT_W-1:0] acc;
  logic [OUT_W-1:0] pp;
  logic [OUT_W-1:0] acc_next;
  logic             last;

  // Both squaring phases share one adder; the phase picks which operand is squared.
  // NOTE: combinational logic uses blocking assignments and gives every output a
  // value on every path, so no latch is inferred.
  always_comb begin
    mult_op  = (state == MUL_A) ? opa : opb;
    pp       = mult_op[cnt] ? (OUT_W'(mult_op) << cnt) : '0;
    acc_next = acc + pp;
    last     = (cnt == CNT_W'(W-1));
  end

  // NOTE: all state is registered with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
      opa   <= '0;
      opb   <= '0;
      acc   <= '0;
      cnt   <= '0;
      y_bo  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_i) begin
            opa   <= a_bi;
            opb   <= b_bi;
            acc   <= '0;
            cnt   <= '0;
            state <= MUL_A;
          end
        end
        MUL_A: begin
          acc <= acc_next;
          cnt <= cnt + CNT_W'(1);
          if (last) begin
            cnt   <= '0;
            state <= MUL_B;
          end
        end
        MUL_B: begin
          acc <= acc_next;
          cnt <= cnt + CNT_W'(1);
          if (last) begin
            cnt   <= '0;
            y_bo  <= acc_next;  // includes the final partial product
            state <= SEND;
          end
        end
        SEND: begin
          if (!sq_busy_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy_o     = (state != IDLE);
  assign sq_start_o = (state == SEND) && !sq_busy_i;

endmodule

// File: tb/tb_sum_sq_feed.sv
// Self-checking bench for sum_sq_feed: directed cases plus randomized requests
// checked against a plain-arithmetic model of the cycle-level handshake.
module tb_sum_sq_feed;

  localparam int W    = 8;
  localparam int LAST = 2*W;  // cycle index (after accept edge) when SEND is entered

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [W-1:0] a_bi = '0;
  logic [W-1:0] b_bi = '0;
  logic        start_i = 1'b0;
  logic        sq_busy_i = 1'b0;
  logic        busy_o;
  logic        sq_start_o;
  logic [2*W:0] y_bo;

  int n_checks = 0;
  int n_fail   = 0;
  int prev_y   = 0;

  sum_sq_feed #(.W(W)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .a_bi       (a_bi),
    .b_bi       (b_bi),
    .start_i    (start_i),
    .busy_o     (busy_o),
    .y_bo       (y_bo),
    .sq_start_o (sq_start_o),
    .sq_busy_i  (sq_busy_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural sqrt stage: floor square root.
  function automatic int isqrt(input int x);
    int r = 0;
    while ((r+1)*(r+1) <= x) r++;
    return r;
  endfunction

  // One request: accept at edge 0; cycle k is the window after edge k.
  // stall = cycles sq_busy_i is held high after SEND entry.
  // inject_k >= 0 pulses start_i (a=b=9) during that cycle, which must be ignored.
  task automatic run_req(input int a, input int b, input int stall,
                         input int inject_k, input int exp_root);
    int exp_y = a*a + b*b;
    check("idle_before_start", busy_o, 0);
    a_bi      = W'(a);
    b_bi      = W'(b);
    start_i   = 1'b1;
    sq_busy_i = 1'b0;
    for (int k = 0; k <= LAST + stall + 1; k++) begin
      @(posedge clk_i); #1;
      start_i = (k == inject_k);
      if (k == inject_k) begin
        a_bi = 9; b_bi = 9;
      end else begin
        a_bi = W'($urandom); b_bi = W'($urandom);
      end
      sq_busy_i = (k < LAST) ? 1'($urandom) : (k < LAST + stall);
      #1;
      check($sformatf("busy k=%0d", k), busy_o, (k <= LAST + stall) ? 1 : 0);
      check($sformatf("sq_start k=%0d", k), sq_start_o, (k == LAST + stall) ? 1 : 0);
      check($sformatf("y a=%0d b=%0d k=%0d", a, b, k), y_bo, (k < LAST) ? prev_y : exp_y);
      if (sq_start_o && exp_root >= 0)
        check("sqrt_result", isqrt(int'(y_bo)), exp_root);
    end
    start_i   = 1'b0;
    sq_busy_i = 1'b0;
    prev_y    = exp_y;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    #1;
    check("reset_busy", busy_o, 0);
    check("reset_sq_start", sq_start_o, 0);
    check("reset_y", y_bo, 0);
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b1;
    #1;

    // Directed cases, the first two back-to-back through the sqrt stage.
    run_req(3, 4, 0, -1, 5);
    run_req(5, 12, 0, -1, 13);
    run_req(255, 255, 0, -1, -1);
    check("max_value", y_bo, 130050);
    run_req(0, 0, 0, -1, 0);
    run_req(200, 1, 5, -1, -1);

    // Start during MUL_A is ignored; the next request works normally.
    run_req(1, 2, 0, 3, -1);
    run_req(9, 9, 0, -1, -1);

    // Reset mid-MUL_B aborts the request.
    a_bi    = 50;
    b_bi    = 60;
    start_i = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk_i); #1;
      start_i = 1'b0;
    end
    check("mid_op_busy", busy_o, 1);
    rst_i = 1'b0;
    #1;
    check("abort_busy", busy_o, 0);
    check("abort_y", y_bo, 0);
    check("abort_sq_start", sq_start_o, 0);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk_i); #1;
      check("abort_no_pulse", sq_start_o, 0);
      if (k == 3) rst_i = 1'b1;
    end
    prev_y = 0;
    run_req(6, 8, 0, -1, 10);

    // Randomized requests.
    for (int i = 0; i < 20; i++) begin
      int a  = $urandom_range(0, 255);
      int b  = $urandom_range(0, 255);
      int st = $urandom_range(0, 3);
      int ij = ($urandom_range(0, 1) == 1) ? $urandom_range(1, LAST - 1) : -1;
      run_req(a, b, st, ij, isqrt(a*a + b*b));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
